// File: rtl/nios_system_oci_trace_pkg.sv
// Shared definitions for the OCI trace monitor: FSM encodings, default
// frame widths and a constant-safe clog2 helper.
package nios_system_oci_trace_pkg;

  localparam logic [1:0] ST_CAPTURE = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int DCT_W_DEF = 30;
  localparam int CNT_W_DEF = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/nios_system_oci_trace_fifo.sv
// Synchronous show-ahead FIFO. The head becomes visible one cycle after it is
// written, because the read side compares against a delayed copy of the
// write pointer. Full/empty use the real write pointer so capacity is exact.
module nios_system_oci_trace_fifo
  import nios_system_oci_trace_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_last,
  output logic         o_valid,
  output logic [W-1:0] o_head
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_wptr_vis;
  logic [PW-1:0] r_rptr;
  logic          w_pop;
  logic          w_push;

  assign o_valid = (r_rptr != r_wptr_vis);
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_last  = ((r_wptr - r_rptr) == PW'(1));
  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign w_pop   = i_pop && o_valid;
  assign w_push  = i_push && (!o_full || w_pop);

  // Storage write; contents need no reset since visibility is pointer-gated.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  // Pointer update; the visible write pointer trails the real one by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_wptr_vis <= '0;
      r_rptr     <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_wptr_vis <= r_wptr;
    end
  end

endmodule

// File: rtl/nios_system_nios2_qsys_1_oci_trace_monitor.sv
// Captures OCI debug-capture-trace frames into a FIFO, streams them out over
// valid/ready, tracks counters/checksum/error flags and sequences test end.
module nios_system_nios2_qsys_1_oci_trace_monitor
  import nios_system_oci_trace_pkg::*;
#(
  parameter int DCT_W     = DCT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_COUNT = 10,
  parameter int DEPTH     = 16,
  parameter int SUM_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dct_valid,
  input  logic [DCT_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]       dct_count,
  input  logic                   test_ending,
  output logic                   out_valid,
  output logic [CNT_W+DCT_W-1:0] out_data,
  input  logic                   out_ready,
  output logic                   test_has_ended,
  output logic                   overflow,
  output logic                   malformed,
  output logic [SUM_W-1:0]       frame_total,
  output logic [SUM_W-1:0]       frame_dropped,
  output logic [SUM_W-1:0]       checksum
);

  logic [1:0]             r_state;
  logic                   r_overflow;
  logic                   r_malformed;
  logic [SUM_W-1:0]       r_total;
  logic [SUM_W-1:0]       r_dropped;
  logic [SUM_W-1:0]       r_checksum;

  logic                   w_frame;
  logic                   w_too_long;
  logic                   w_legal;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_last;
  logic                   w_fifo_valid;
  logic [CNT_W+DCT_W-1:0] w_head;

  // Frames are only considered while capturing; empty frames are ignored.
  assign w_frame    = (r_state == ST_CAPTURE) && dct_valid && (dct_count != '0);
  assign w_too_long = w_frame && (int'(dct_count) > MAX_COUNT);
  assign w_legal    = w_frame && !w_too_long;
  assign w_pop      = w_fifo_valid && out_ready;
  // A same-cycle pop frees the slot a full FIFO needs for the new frame.
  assign w_push     = w_legal && (!w_full || w_pop);
  assign w_drop     = w_legal && w_full && !w_pop;

  nios_system_oci_trace_fifo #(
    .W     (CNT_W + DCT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({dct_count, dct_buffer}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_last  (w_last),
    .o_valid (w_fifo_valid),
    .o_head  (w_head)
  );

  // End-of-test sequencing; the drain check accounts for this cycle's pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CAPTURE;
    end else begin
      case (r_state)
        ST_CAPTURE: if (test_ending) r_state <= ST_DRAIN;
        ST_DRAIN:   if (w_empty || (w_last && w_pop)) r_state <= ST_DONE;
        ST_DONE:    r_state <= ST_DONE;
        default:    r_state <= ST_CAPTURE;
      endcase
    end
  end

  // Frame statistics and sticky error flags; counters wrap silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_malformed <= 1'b0;
      r_total     <= '0;
      r_dropped   <= '0;
      r_checksum  <= '0;
    end else begin
      if (w_too_long) r_malformed <= 1'b1;
      if (w_push) begin
        r_total    <= r_total + SUM_W'(1);
        r_checksum <= r_checksum + SUM_W'(dct_buffer);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_dropped  <= r_dropped + SUM_W'(1);
      end
    end
  end

  assign out_valid      = w_fifo_valid;
  assign out_data       = w_fifo_valid ? w_head : '0;
  assign test_has_ended = (r_state == ST_DONE);
  assign overflow       = r_overflow;
  assign malformed      = r_malformed;
  assign frame_total    = r_total;
  assign frame_dropped  = r_dropped;
  assign checksum       = r_checksum;

endmodule
